// File: rtl/scatter_wb.sv
// Write-back stage: buffers read-engine beats in a FIFO and drains them to host memory as AXI4 write bursts.
// Optional WB_BYTESWAP_EN reverses the 64-bit lanes of each written beat.
module scatter_wb #(
  parameter int unsigned AXI_DW     = 512,
  parameter int unsigned AXI_AW     = 64,
  parameter int unsigned BURST_MAX  = 64,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              cfg_start,
  input  logic [AXI_AW-1:0] cfg_wb_addr,
  input  logic [31:0]       cfg_block_size,
  input  logic [31:0]       cfg_block_num,
  input  logic              i_valid,
  input  logic [AXI_DW-1:0] i_data,
  input  logic [2:0]        i_resp,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [AXI_AW-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [AXI_DW-1:0] m_wdata,
  output logic              m_wvalid,
  output logic              m_wlast,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = $clog2(BURST_MAX) + 1;
  localparam int unsigned LANES = AXI_DW / 64;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [AXI_DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  logic [31:0]       r_remaining;
  logic [AXI_AW-1:0] r_addr;
  logic [LW-1:0]     r_len, r_wcnt;
  logic              r_awvalid;
  logic [AXI_AW-1:0] r_awaddr;
  logic [7:0]        r_awlen;
  logic              r_err;

  logic [31:0]       w_beats_total, w_rem_after;
  logic [LW-1:0]     w_len;
  logic              w_fifo_empty, w_fifo_full;
  logic              w_start, w_push, w_pop, w_wr, w_ovf;
  logic              w_aw_fire, w_last_fire, w_b_fire;
  logic [AXI_DW-1:0] w_head;
  logic              w_unused;

  assign w_unused      = ^cfg_block_size[5:0];
  assign w_beats_total = cfg_block_num * {6'd0, cfg_block_size[31:6]};
  assign w_len         = (r_remaining >= BURST_MAX) ? LW'(BURST_MAX) : LW'(r_remaining);
  assign w_rem_after   = r_remaining - 32'(r_len);
  assign w_fifo_empty  = (r_count == '0);
  assign w_fifo_full   = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_start       = cfg_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_push        = i_valid && o_busy;
  assign w_pop         = m_wvalid && m_wready;
  assign w_wr          = w_push && (!w_fifo_full || w_pop);
  assign w_ovf         = w_push && w_fifo_full && !w_pop;
  assign w_aw_fire     = r_awvalid && m_awready;
  assign w_last_fire   = w_pop && m_wlast;
  assign w_b_fire      = (r_state == S_B) && m_bvalid;
  assign w_head        = r_mem[r_rd_ptr];

  assign m_awvalid = r_awvalid;
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign o_err     = r_err;

`ifdef WB_BYTESWAP_EN
  always_comb begin
    m_wdata = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      m_wdata[64*k +: 64] = w_head[64*(LANES-1-k) +: 64];
    end
  end
`else
  assign m_wdata = w_head;
`endif

  always_ff @(posedge axi_clk) begin
    if (axi_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        o_done = (r_state == S_DONE);
        if (cfg_start) w_state_nxt = (w_beats_total == '0) ? S_DONE : S_AW;
      end
      S_AW: begin
        o_busy = 1'b1;
        if (w_aw_fire) w_state_nxt = S_W;
      end
      S_W: begin
        o_busy   = 1'b1;
        m_wvalid = !w_fifo_empty;
        m_wlast  = !w_fifo_empty && (r_wcnt == r_len - LW'(1));
        if (w_last_fire) w_state_nxt = S_B;
      end
      S_B: begin
        o_busy   = 1'b1;
        m_bready = 1'b1;
        if (m_bvalid) w_state_nxt = (w_rem_after == '0) ? S_DONE : S_AW;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_remaining <= w_beats_total;
        r_addr      <= cfg_wb_addr;
        r_err       <= 1'b0;
      end
      // AW is only offered once the whole burst is buffered, so W can never starve.
      if (r_state == S_AW) begin
        if (!r_awvalid && r_count >= (PW+1)'(w_len)) begin
          r_awvalid <= 1'b1;
          r_awaddr  <= r_addr;
          r_awlen   <= 8'(w_len - LW'(1));
          r_len     <= w_len;
        end else if (w_aw_fire) begin
          r_awvalid <= 1'b0;
        end
      end
      if (w_last_fire)  r_wcnt <= '0;
      else if (w_pop)   r_wcnt <= r_wcnt + LW'(1);
      if (w_b_fire) begin
        r_addr      <= r_addr + (AXI_AW'(r_len) << 6);
        r_remaining <= w_rem_after;
      end
      if ((w_push && i_resp != 3'd0) || w_ovf || (w_b_fire && m_bresp != 2'd0)) r_err <= 1'b1;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_scatter_wb.sv
// Directed bench for scatter_wb: a queue-based transfer model checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_scatter_wb;
  logic         axi_clk = 1'b0;
  logic         axi_rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic [63:0]  cfg_wb_addr = '0;
  logic [31:0]  cfg_block_size = '0, cfg_block_num = '0;
  logic         i_valid = 1'b0;
  logic [511:0] i_data = '0;
  logic [2:0]   i_resp = '0;
  logic         o_busy, o_done, o_err;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic         m_awvalid, m_wvalid, m_wlast, m_bready;
  logic         m_awready = 1'b1, m_wready = 1'b1, m_bvalid = 1'b0;
  logic [511:0] m_wdata;
  logic [1:0]   m_bresp = '0;

  scatter_wb #(.AXI_DW(512), .AXI_AW(64), .BURST_MAX(64), .FIFO_DEPTH(128)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .cfg_start(cfg_start), .cfg_wb_addr(cfg_wb_addr),
    .cfg_block_size(cfg_block_size), .cfg_block_num(cfg_block_num),
    .i_valid(i_valid), .i_data(i_data), .i_resp(i_resp),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready));

  initial forever #2 axi_clk = ~axi_clk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int unsigned s);
    logic [511:0] d;
    for (int unsigned k = 0; k < 8; k++) d[64*k +: 64] = {s, k};
    return d;
  endfunction

  function automatic logic [511:0] exp_out(input logic [511:0] d);
    logic [511:0] r;
    r = d;
`ifdef WB_BYTESWAP_EN
    for (int unsigned k = 0; k < 8; k++) r[64*k +: 64] = d[64*(7-k) +: 64];
`endif
    return r;
  endfunction

  // Transfer model: FIFO contents as a queue, burst plan as a list of lengths.
  logic [511:0] mq[$];
  int           m_blen[$];
  logic [63:0]  m_base;
  bit           m_busy, m_done, m_err, m_pop;
  int           aw_idx, w_bi, w_beat, b_idx;
  int unsigned  t_tot;
  int           t_len;

  logic [63:0]  aw_log_addr[64];
  logic [7:0]   aw_log_len[64];
  logic [511:0] w_data_log[1024];
  logic [31:0]  w_seq_log[1024];
  int           aw_n = 0, w_n = 0, b_n = 0;
  int           bad_b_num = -1;
  int           aw_mode = 0, wr_mode = 1, cyc = 0;
  int unsigned  g_seq = 0;

  always @(negedge axi_clk) begin
    if (axi_rst) begin
      mq.delete(); m_blen.delete();
      m_busy = 0; m_done = 0; m_err = 0;
      aw_idx = 0; w_bi = 0; w_beat = 0; b_idx = 0;
    end else begin
      chk("busy", 512'(o_busy), 512'(m_busy));
      chk("done", 512'(o_done), 512'(m_done));
      chk("err", 512'(o_err), 512'(m_err));
      if (m_awvalid) begin
        if (aw_idx >= m_blen.size() || aw_idx != b_idx) chk("aw_unexpected", 512'(1), 512'(0));
        else begin
          chk("awaddr", 512'(m_awaddr), 512'(m_base + 64'(aw_idx) * 64'd4096));
          chk("awlen", 512'(m_awlen), 512'(m_blen[aw_idx] - 1));
          chk("aw_buffered", 512'(mq.size() >= m_blen[aw_idx]), 512'(1));
          if (m_awready) aw_idx++;
        end
        if (m_awready && aw_n < 64) begin
          aw_log_addr[aw_n] = m_awaddr; aw_log_len[aw_n] = m_awlen; aw_n++;
        end
      end
      m_pop = 0;
      if (m_wvalid) begin
        if (w_bi >= aw_idx || mq.size() == 0) chk("w_unexpected", 512'(1), 512'(0));
        else if (m_wready) begin
          chk("wdata", m_wdata, exp_out(mq[0]));
          chk("wlast", 512'(m_wlast), 512'(w_beat == m_blen[w_bi] - 1));
          void'(mq.pop_front());
          m_pop = 1;
          if (w_beat == m_blen[w_bi] - 1) begin w_bi++; w_beat = 0; end
          else w_beat++;
        end
        if (m_wready && w_n < 1024) begin
          w_data_log[w_n] = m_wdata; w_seq_log[w_n] = m_wdata[63:32]; w_n++;
        end
      end
      if (i_valid && m_busy) begin
        if (mq.size() < 128) mq.push_back(i_data);
        else m_err = 1;
        if (i_resp != 3'd0) m_err = 1;
      end
      if (m_bvalid && m_bready) begin
        if (b_idx >= w_bi) chk("b_unexpected", 512'(1), 512'(0));
        else begin
          if (m_bresp != 2'd0) m_err = 1;
          b_idx++;
          if (b_idx == m_blen.size()) begin m_busy = 0; m_done = 1; end
        end
      end
      if (cfg_start && !m_busy) begin
        t_tot = cfg_block_num * (cfg_block_size >> 6);
        m_base = cfg_wb_addr;
        m_blen.delete();
        aw_idx = 0; w_bi = 0; w_beat = 0; b_idx = 0; m_err = 0;
        while (t_tot > 0) begin
          t_len = (t_tot > 64) ? 64 : int'(t_tot);
          m_blen.push_back(t_len);
          t_tot = t_tot - t_len;
        end
        m_busy = (m_blen.size() != 0);
        m_done = !m_busy;
      end
    end
  end

  initial begin
    forever begin
      @(posedge axi_clk); #1;
      cyc++;
      m_awready = (aw_mode == 0) || (cyc % 4 == 0);
      m_wready  = (wr_mode == 1) || (wr_mode == 2 && cyc % 3 != 0);
    end
  end

  initial begin
    bit got;
    forever begin
      @(negedge axi_clk);
      if (!axi_rst && m_wvalid && m_wready && m_wlast) begin
        @(posedge axi_clk); #1;
        m_bvalid = 1'b1;
        m_bresp  = (b_n == bad_b_num) ? 2'b10 : 2'b00;
        got = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge axi_clk);
          if (m_bready) begin got = 1; break; end
        end
        if (!got) chk("bready_timeout", 512'(0), 512'(1));
        @(posedge axi_clk); #1;
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        b_n++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge axi_clk); #1 axi_rst = 1'b1;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_busy", 512'(o_busy), 512'(0));
    chk("rst_done", 512'(o_done), 512'(0));
    chk("rst_err", 512'(o_err), 512'(0));
    chk("rst_awvalid", 512'(m_awvalid), 512'(0));
    chk("rst_wvalid", 512'(m_wvalid), 512'(0));
    chk("rst_wlast", 512'(m_wlast), 512'(0));
    chk("rst_bready", 512'(m_bready), 512'(0));
    chk("rst_awaddr", 512'(m_awaddr), 512'(0));
    chk("rst_awlen", 512'(m_awlen), 512'(0));
    @(posedge axi_clk); #1 axi_rst = 1'b0;
  endtask

  task automatic start(input logic [63:0] a, input logic [31:0] sz, input logic [31:0] nm);
    cfg_wb_addr = a; cfg_block_size = sz; cfg_block_num = nm;
    @(posedge axi_clk); #1 cfg_start = 1'b1;
    @(posedge axi_clk); #1 cfg_start = 1'b0;
  endtask

  task automatic push_raw(input logic [511:0] d, input logic [2:0] resp);
    i_valid = 1'b1; i_data = d; i_resp = resp;
    @(posedge axi_clk); #1;
    i_valid = 1'b0; i_resp = '0;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1; i_data = mk(g_seq); i_resp = '0; g_seq++;
      @(posedge axi_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge axi_clk);
      if (o_done) break;
    end
    chk("done_reached", 512'(o_done), 512'(1));
    @(posedge axi_clk); #1;
  endtask

  initial begin
    int awb, wb;
    int unsigned s0;
    logic [511:0] lanes, lanes_exp, fill;

    do_reset();

    // one full 4 KiB burst; a beat offered while idle must be dropped
    push(1);
    awb = aw_n; wb = w_n;
    start(64'h1000, 32'd4096, 32'd1);
    push(64);
    wait_done(400);
    chk("t1_aw_count", 512'(aw_n - awb), 512'(1));
    chk("t1_awaddr", 512'(aw_log_addr[awb]), 512'(64'h1000));
    chk("t1_awlen", 512'(aw_log_len[awb]), 512'(63));
    chk("t1_w_count", 512'(w_n - wb), 512'(64));
    chk("t1_err", 512'(o_err), 512'(0));

    // 100 beats split 64 + 36 with throttled ready signals
    aw_mode = 1; wr_mode = 2;
    awb = aw_n; wb = w_n;
    start(64'h40000, 32'd64, 32'd100);
    push(100);
    wait_done(1500);
    chk("t2_aw_count", 512'(aw_n - awb), 512'(2));
    chk("t2_awaddr0", 512'(aw_log_addr[awb]), 512'(64'h40000));
    chk("t2_awlen0", 512'(aw_log_len[awb]), 512'(63));
    chk("t2_awaddr1", 512'(aw_log_addr[awb+1]), 512'(64'h41000));
    chk("t2_awlen1", 512'(aw_log_len[awb+1]), 512'(35));
    chk("t2_w_count", 512'(w_n - wb), 512'(100));
    aw_mode = 0; wr_mode = 1;

    // zero blocks: straight to DONE, no AW
    do_reset();
    awb = aw_n;
    start(64'h5000, 32'd4096, 32'd0);
    @(negedge axi_clk);
    chk("t3_done", 512'(o_done), 512'(1));
    chk("t3_busy", 512'(o_busy), 512'(0));
    repeat (5) @(posedge axi_clk);
    #1;
    chk("t3_aw_count", 512'(aw_n - awb), 512'(0));

    // overflow: 129 beats with W stalled, beat 129 dropped
    wr_mode = 0;
    @(posedge axi_clk); #1;
    awb = aw_n; wb = w_n; s0 = g_seq;
    start(64'h10000, 32'd64, 32'd200);
    push(129);
    @(negedge axi_clk);
    chk("t4_err_overflow", 512'(o_err), 512'(1));
    @(posedge axi_clk); #1;
    wr_mode = 1;
    repeat (300) @(posedge axi_clk);
    #1;
    push(72);
    wait_done(1500);
    chk("t4_w_count", 512'(w_n - wb), 512'(200));
    chk("t4_beat128", 512'(w_seq_log[wb+127]), 512'(s0 + 127));
    chk("t4_beat129", 512'(w_seq_log[wb+128]), 512'(s0 + 129));
    chk("t4_aw_count", 512'(aw_n - awb), 512'(4));
    chk("t4_last_awaddr", 512'(aw_log_addr[awb+3]), 512'(64'h13000));
    chk("t4_last_awlen", 512'(aw_log_len[awb+3]), 512'(7));
    chk("t4_err", 512'(o_err), 512'(1));

    // error response on the first burst; transfer still completes
    bad_b_num = b_n;
    awb = aw_n;
    start(64'h8000, 32'd4096, 32'd2);
    push(128);
    wait_done(1500);
    chk("t5_err", 512'(o_err), 512'(1));
    chk("t5_aw_count", 512'(aw_n - awb), 512'(2));
    bad_b_num = -1;

    // lane ordering and nonzero read response
    for (int unsigned k = 0; k < 8; k++) begin
      lanes[64*k +: 64] = 64'(k + 1);
`ifdef WB_BYTESWAP_EN
      lanes_exp[64*k +: 64] = 64'(8 - k);
`else
      lanes_exp[64*k +: 64] = 64'(k + 1);
`endif
    end
    awb = aw_n; wb = w_n;
    start(64'h2000, 32'd128, 32'd1);
    push_raw(lanes, 3'b000);
    push_raw(mk(g_seq), 3'b001);
    g_seq++;
    wait_done(200);
    chk("t6_lanes", w_data_log[wb], lanes_exp);
    chk("t6_awlen", 512'(aw_log_len[awb]), 512'(1));
    chk("t6_err_resp", 512'(o_err), 512'(1));

    // reset mid-transfer flushes buffered beats
    start(64'h3000, 32'd4096, 32'd1);
    push(10);
    do_reset();
    fill = {8{64'hDEAD_BEEF_0000_0007}};
    wb = w_n;
    start(64'h3000, 32'd64, 32'd1);
    push_raw(fill, 3'b000);
    wait_done(200);
    chk("t7_flushed", w_data_log[wb], fill);
    chk("t7_w_count", 512'(w_n - wb), 512'(1));

    repeat (3) @(posedge axi_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
